risky_decode: RTL
=================

Name: risky_decode

Overview:
- Decode/issue stage that produces the ALU control word `{F7 bit, F3}` and the operands consumed by risky_alu.
- Accepts 32-bit RV32I instructions from fetch over a valid/ready handshake and reads two register-file ports.
- Tracks in-flight destination registers in a busy scoreboard, stalls on RAW hazards, and holds one decoded instruction in an output register until the execute stage takes it.
- Supports the OP (0110011) and OP-IMM (0010011) opcodes; everything else is flagged illegal.

Parameters:
- XLEN, 32, data/operand width
- NREG, 32, architectural register count (scoreboard size)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  decode accepts this cycle
- in_inst  in  32  instruction word
- rf_raddr1  out  5  rs1 address, combinational from in_inst[19:15]
- rf_raddr2  out  5  rs2 address, combinational from in_inst[24:20]
- rf_rdata1  in  XLEN  rs1 data, combinational from the register file
- rf_rdata2  in  XLEN  rs2 data, combinational from the register file
- wb_valid  in  1  writeback this cycle
- wb_rd  in  5  writeback destination
- wb_data  in  XLEN  writeback value
- out_valid  out  1  decoded instruction held
- out_ready  in  1  execute accepts
- out_mode  out  4  ALU mode `{F7 bit, F3}`
- out_a  out  XLEN  operand A (rs1 value)
- out_b  out  XLEN  operand B (rs2 value or immediate)
- out_rd  out  5  destination register
- out_we  out  1  result to be written back
- out_illegal  out  1  instruction not supported

Behaviour:
- Reset:
  - out_valid=0; out_mode, out_a, out_b, out_rd all 0; out_we=0; out_illegal=0.
  - All scoreboard bits are cleared.
  - An instruction held in the output register at reset is discarded.
- Accept condition (accept = in_valid & in_ready):
  - in_ready = (!out_valid | out_ready) & !hazard.
  - Decoded fields load into the output register on the next edge; out_valid=1 from that edge.
  - Latency is 1 cycle from accept to out_valid.
- Output register holding:
  - Contents stay stable while out_valid & !out_ready.
  - On out_ready with no new accept, out_valid drops to 0.
  - Back-to-back accept while out_ready=1 gives full throughput.
- OP decode:
  - mode = `{inst[30], inst[14:12]}`; b = rs2 value.
  - Legal only if funct7 = 0000000, or funct7 = 0100000 with F3 = 000 or 101.
- OP-IMM decode:
  - b = sign-extended inst[31:20].
  - mode F7 bit is forced 0 except for F3 = 101, where it is inst[30]. ADDI with a negative immediate must yield mode 0000.
  - F3 = 001 requires inst[31:25] = 0000000; F3 = 101 requires inst[31:25] to be 0000000 or 0100000. Otherwise the instruction is illegal.
- Destination and write enable:
  - rd = inst[11:7].
  - out_we = legal & (rd != 0).
- Illegal instructions:
  - out_illegal=1, out_we=0, mode/a/b=0.
  - Never stall on hazards; never touch the scoreboard.
- Scoreboard:
  - busy[rd] is set on accept when out_we will be 1.
  - busy[wb_rd] is cleared when wb_valid and wb_rd != 0.
  - If set and clear target the same register in the same cycle, set wins.
  - x0 is never busy.
- Hazard:
  - hazard = legal & ((rs1 busy & !byp1) | (uses rs2 & rs2 busy & !byp2)).
  - OP-IMM does not use rs2.
- Writeback bypass:
  - byp1 = wb_valid & wb_rd == rs1 & rs1 != 0; when asserted, a = wb_data instead of rf_rdata1.
  - byp2 is the same for rs2.
  - Bypass takes priority over the register-file data.
- Operand x0 always reads as 0 regardless of rf data.
- Operand width: all operand paths are XLEN wide with no truncation; the immediate sign-extends from bit 31 of the instruction.

Test Plan:
- After reset, issue `ADD x3,x1,x2` (0x002081B3) with rf x1=5, x2=7 and out_ready=1 -> the next cycle shows out_valid=1, mode=0000, a=5, b=7, rd=3, we=1, illegal=0.
- Issue `SUB x4,x1,x2` (0x40208233) -> mode=1000. Issue `ADDI x5,x0,-1` (0xFFF00293) -> mode=0000, a=0, b=0xFFFFFFFF.
- ADD x3 is accepted, then `ADD x6,x3,x3` is presented with no writeback -> in_ready=0 until wb_valid, wb_rd=3, wb_data=0x55. In that wb cycle it is accepted with a=b=0x55; busy[3] is cleared and busy[6] is set.
- Hold out_ready=0 with out_valid=1 and a new in_valid -> in_ready=0 and outputs unchanged for 5 cycles. Raise out_ready -> the new instruction appears the next cycle with no loss or duplication.
- Present opcode 0x00000073 (SYSTEM) while x3 is busy -> accepted without stall; illegal=1, we=0, scoreboard unchanged.
- Assert rst while out_valid=1 and busy[3]=1 -> the next cycle shows out_valid=0 with all busy bits clear. A following `ADD x6,x3,x3` is accepted immediately.

Source files
------------

// File: rtl/risky_decode.sv
// Decode/issue stage for risky_alu: RV32I OP/OP-IMM decode, RAW scoreboard with
// writeback bypass, and a single-entry output register toward execute.
module risky_decode #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   output logic [4:0]      rf_raddr1,
   output logic [4:0]      rf_raddr2,
   input  logic [XLEN-1:0] rf_rdata1,
   input  logic [XLEN-1:0] rf_rdata2,
   input  logic            wb_valid,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      out_mode,
   output logic [XLEN-1:0] out_a,
   output logic [XLEN-1:0] out_b,
   output logic [4:0]      out_rd,
   output logic            out_we,
   output logic            out_illegal
);

   // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
   // valid never depends on ready, and the sender holds its payload until it transfers.
   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] F7_ZERO   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;

   logic [6:0]      opcode, f7;
   logic [2:0]      f3;
   logic [4:0]      rs1, rs2, rd;
   logic            is_op, is_opimm, legal;
   logic            byp1, byp2, hazard, accept;
   logic [XLEN-1:0] rs1_val, rs2_val, imm;
   logic [3:0]      dec_mode;
   logic [XLEN-1:0] dec_a, dec_b;
   logic            dec_we;
   logic [NREG-1:0] busy;

   assign opcode    = in_inst[6:0];
   assign rd        = in_inst[11:7];
   assign f3        = in_inst[14:12];
   assign rs1       = in_inst[19:15];
   assign rs2       = in_inst[24:20];
   assign f7        = in_inst[31:25];
   assign rf_raddr1 = rs1;
   assign rf_raddr2 = rs2;

   assign is_op    = (opcode == OPC_OP);
   assign is_opimm = (opcode == OPC_OPIMM);

   always_comb begin
      legal = 1'b0;
      if (is_op)
         legal = (f7 == F7_ZERO) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
      else if (is_opimm) begin
         if (f3 == 3'b001)
            legal = (f7 == F7_ZERO);
         else if (f3 == 3'b101)
            legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
         else
            legal = 1'b1;
      end
   end

   // A writeback landing this cycle both resolves the hazard and supplies the operand.
   assign byp1    = wb_valid && (wb_rd == rs1) && (rs1 != 5'd0);
   assign byp2    = wb_valid && (wb_rd == rs2) && (rs2 != 5'd0);
   assign rs1_val = (rs1 == 5'd0) ? '0 : (byp1 ? wb_data : rf_rdata1);
   assign rs2_val = (rs2 == 5'd0) ? '0 : (byp2 ? wb_data : rf_rdata2);
   assign imm     = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};

   assign hazard   = legal && ((busy[rs1] && !byp1) || (is_op && busy[rs2] && !byp2));
   assign in_ready = (!out_valid || out_ready) && !hazard;
   assign accept   = in_valid && in_ready;

   always_comb begin
      dec_mode = 4'd0;
      dec_a    = '0;
      dec_b    = '0;
      dec_we   = 1'b0;
      if (legal) begin
         dec_a  = rs1_val;
         dec_we = (rd != 5'd0);
         if (is_op) begin
            dec_mode = {in_inst[30], f3};
            dec_b    = rs2_val;
         end else begin
            dec_mode = {(f3 == 3'b101) ? in_inst[30] : 1'b0, f3};
            dec_b    = imm;
         end
      end
   end

   // Set is evaluated before clear so a same-register collision leaves the bit set.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (accept && dec_we && (rd == i[4:0]))
               busy[i] <= 1'b1;
            else if (wb_valid && (wb_rd == i[4:0]))
               busy[i] <= 1'b0;
         end
         busy[0] <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_mode    <= 4'd0;
         out_a       <= '0;
         out_b       <= '0;
         out_rd      <= 5'd0;
         out_we      <= 1'b0;
         out_illegal <= 1'b0;
      end else if (accept) begin
         out_valid   <= 1'b1;
         out_mode    <= dec_mode;
         out_a       <= dec_a;
         out_b       <= dec_b;
         out_rd      <= rd;
         out_we      <= dec_we;
         out_illegal <= !legal;
      end else if (out_ready) begin
         out_valid   <= 1'b0;
      end
   end

endmodule
